// File: rtl/next_hop_selector.sv
// next_hop_selector
//   Walks the neighbor table once per accepted start pulse, one entry per
//   cycle, and keeps the best eligible neighbor. The best neighbor has the
//   highest Q-value. Among equal Q-values, the one with fewer hops wins.
//   On a full tie, the lower index wins.
//   Optional macro NEXT_HOP_ENERGY_FILTER_EN: an entry is eligible only if
//   mNodeEnergy >= minEnergy (minEnergy is latched at start). When the macro
//   is undefined, every entry is eligible and minEnergy is ignored.
// Ports:
//   clk, nrst (synchronous, active-high reset), start
//   neighborCount, minEnergy           : scan configuration, latched at start
//   rd_en, rd_addr                     : table read port (data returns next cycle)
//   mNodeID/Hops/QValue/Energy         : table read data
//   busy, done, valid                  : status
//   bestID, bestHops, bestQValue, bestIdx : winning entry
module next_hop_selector #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 16,
  parameter int IDX_WIDTH     = $clog2(MAX_NEIGHBORS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  input  logic [WORD_WIDTH-1:0] minEnergy,
  output logic                  rd_en,
  output logic [IDX_WIDTH-1:0]  rd_addr,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeEnergy,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] bestID,
  output logic [WORD_WIDTH-1:0] bestHops,
  output logic [WORD_WIDTH-1:0] bestQValue,
  output logic [IDX_WIDTH-1:0]  bestIdx
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   addr_q;
  logic [IDX_WIDTH-1:0]   last_q, last_d;
  logic [IDX_WIDTH-1:0]   eval_idx_q;
  logic                   eval_q;
  logic                   count_zero;
  logic                   accept;
  logic                   eligible;
  logic                   better;

  assign accept     = (state_q == IDLE) && start;
  assign count_zero = (neighborCount == '0);

  // Last index to read is min(count, MAX_NEIGHBORS) - 1.
  always_comb begin
    last_d = IDX_WIDTH'(MAX_NEIGHBORS - 1);
    if (neighborCount < WORD_WIDTH'(MAX_NEIGHBORS))
      last_d = IDX_WIDTH'(neighborCount - WORD_WIDTH'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (nrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = count_zero ? DONE : SCAN;
      SCAN:  if (addr_q == last_q) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode (all derived from registered state)
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    rd_en = (state_q == SCAN);
  end

  assign rd_addr = addr_q;

`ifdef NEXT_HOP_ENERGY_FILTER_EN
  logic [WORD_WIDTH-1:0] min_energy_q;

  always_ff @(posedge clk) begin
    if (nrst)        min_energy_q <= '0;
    else if (accept) min_energy_q <= minEnergy;
  end

  assign eligible = (mNodeEnergy >= min_energy_q);
`else
  logic unused_energy;
  assign unused_energy = ^{minEnergy, mNodeEnergy};
  assign eligible      = 1'b1;
`endif

  // A strict comparison means an equal entry never displaces the one
  // already held, so the lowest index wins on a full tie.
  assign better = eval_q && eligible &&
                  (!valid ||
                   (mNodeQValue > bestQValue) ||
                   ((mNodeQValue == bestQValue) && (mNodeHops < bestHops)));

  // Read address, evaluation pipeline and best-so-far registers.
  // eval_q/eval_idx_q trail the read strobe by one cycle, matching table latency.
  always_ff @(posedge clk) begin
    if (nrst) begin
      addr_q     <= '0;
      last_q     <= '0;
      eval_q     <= 1'b0;
      eval_idx_q <= '0;
      valid      <= 1'b0;
      bestID     <= '0;
      bestHops   <= '0;
      bestQValue <= '0;
      bestIdx    <= '0;
    end else begin
      eval_q     <= (state_q == SCAN);
      eval_idx_q <= addr_q;
      if (accept) begin
        addr_q     <= '0;
        last_q     <= last_d;
        valid      <= 1'b0;
        bestID     <= '0;
        bestHops   <= '0;
        bestQValue <= '0;
        bestIdx    <= '0;
      end else if ((state_q == SCAN) && (addr_q != last_q)) begin
        addr_q <= addr_q + IDX_WIDTH'(1);
      end
      if (better) begin
        valid      <= 1'b1;
        bestID     <= mNodeID;
        bestHops   <= mNodeHops;
        bestQValue <= mNodeQValue;
        bestIdx    <= eval_idx_q;
      end
    end
  end

endmodule

// File: tb/tb_next_hop_selector.sv
// Testbench for next_hop_selector: directed scans, with a neighbor-table
// responder and a per-cycle comparison against a scan-level reference model.
`timescale 1ns/1ps
module tb_next_hop_selector;
  localparam int W    = 16;
  localparam int MAXN = 16;
  localparam int IW   = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  neighborCount = '0;
  logic [W-1:0]  minEnergy = '0;
  logic          rd_en;
  logic [IW-1:0] rd_addr;
  logic [W-1:0]  mNodeID = '0, mNodeHops = '0, mNodeQValue = '0, mNodeEnergy = '0;
  logic          busy, done, valid;
  logic [W-1:0]  bestID, bestHops, bestQValue;
  logic [IW-1:0] bestIdx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] t_id[MAXN], t_hops[MAXN], t_q[MAXN], t_en[MAXN];

  always #5 clk = ~clk;

  next_hop_selector #(.WORD_WIDTH(W), .MAX_NEIGHBORS(MAXN), .IDX_WIDTH(IW)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .neighborCount(neighborCount), .minEnergy(minEnergy),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .mNodeID(mNodeID), .mNodeHops(mNodeHops), .mNodeQValue(mNodeQValue), .mNodeEnergy(mNodeEnergy),
    .busy(busy), .done(done), .valid(valid),
    .bestID(bestID), .bestHops(bestHops), .bestQValue(bestQValue), .bestIdx(bestIdx)
  );

  // Neighbor table: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      mNodeID     <= t_id[rd_addr];
      mNodeHops   <= t_hops[rd_addr];
      mNodeQValue <= t_q[rd_addr];
      mNodeEnergy <= t_en[rd_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_act = 0, m_has = 0, m_addr0 = 0;
  int           m_t = 0, m_n = 0, m_end = 0;
  logic [W-1:0] m_minE;
  logic [W-1:0] s_id[MAXN], s_hops[MAXN], s_q[MAXN], s_en[MAXN];

  function automatic bit elig(input int k);
`ifdef NEXT_HOP_ENERGY_FILTER_EN
    return s_en[k] >= m_minE;
`else
    return 1'b1;
`endif
  endfunction

  // Best of the first cnt entries: highest Q, then fewest hops, then lowest index.
  function automatic void best_of(input int cnt, output bit v, output int idx);
    int maxq = -1;
    int minh = 1 << 20;
    v = 0; idx = 0;
    for (int k = 0; k < cnt; k++)
      if (elig(k) && int'(s_q[k]) > maxq) maxq = int'(s_q[k]);
    if (maxq < 0) return;
    v = 1;
    for (int k = 0; k < cnt; k++)
      if (elig(k) && int'(s_q[k]) == maxq && int'(s_hops[k]) < minh) begin
        minh = int'(s_hops[k]);
        idx  = k;
      end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (nrst) begin
      m_act = 0; m_has = 0; m_addr0 = 1;
    end else if (m_act) begin
      m_t++;
      if (m_t > m_end) m_act = 0;
    end else if (start) begin
      m_act = 1; m_has = 1; m_addr0 = 0; m_t = 1;
      m_n   = (int'(neighborCount) > MAXN) ? MAXN : int'(neighborCount);
      m_end = (m_n == 0) ? 1 : m_n + 2;
      m_minE = minEnergy;
      for (int k = 0; k < MAXN; k++) begin
        s_id[k] = t_id[k]; s_hops[k] = t_hops[k]; s_q[k] = t_q[k]; s_en[k] = t_en[k];
      end
    end
  end

  // Entry k becomes visible in the best registers in cycle k+3 of the scan.
  always @(negedge clk) begin
    bit e_rd, e_v;
    int cnt, e_idx;
    e_rd = m_act && (m_t <= m_n);
    if (!m_has)      cnt = 0;
    else if (m_act)  cnt = (m_t - 2 < 0) ? 0 : ((m_t - 2 > m_n) ? m_n : m_t - 2);
    else             cnt = m_n;
    best_of(cnt, e_v, e_idx);
    chk("busy", busy, m_act);
    chk("done", done, m_act && (m_t == m_end));
    chk("rd_en", rd_en, e_rd);
    if (e_rd)         chk("rd_addr", rd_addr, m_t - 1);
    else if (m_addr0) chk("rd_addr_rst", rd_addr, 0);
    chk("valid", valid, e_v);
    chk("bestIdx", bestIdx, e_v ? e_idx : 0);
    chk("bestID", bestID, e_v ? s_id[e_idx] : 0);
    chk("bestHops", bestHops, e_v ? s_hops[e_idx] : 0);
    chk("bestQValue", bestQValue, e_v ? s_q[e_idx] : 0);
  end

  // ---------------- directed stimulus ----------------
  int addr_log[32];

  task automatic table_default();
    for (int k = 0; k < MAXN; k++) begin
      t_id[k] = W'(100 + k); t_hops[k] = W'(k + 1); t_q[k] = W'(k); t_en[k] = 16'hFFFF;
    end
    minEnergy = '0;
  endtask

  // Called at a negedge while idle; returns at the negedge of the done cycle.
  task automatic run_scan(input int cnt, input int pulse_at, output int dcyc, output int nreads);
    int t;
    start = 1'b1;
    neighborCount = W'(cnt);
    @(negedge clk);
    start = 1'b0;
    t = 1;
    nreads = 0;
    chk("start_clears_valid", valid, 0);
    chk("start_sets_busy", busy, 1);
    while (t < 200) begin
      if (rd_en) begin
        if (nreads < 32) addr_log[nreads] = int'(rd_addr);
        nreads++;
      end
      if (done) break;
      start = (t == pulse_at);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk("done_within_bound", done, 1);
    dcyc = t;
  endtask

  initial begin
    int dc, nr;
    table_default();
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // Reset in cycle 3 of an N=8 scan
    start = 1'b1; neighborCount = 16'd8;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_rd_addr", rd_addr, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_bestIdx", bestIdx, 0);
    chk("rst_mid_bestQ", bestQValue, 0);
    nrst = 1'b0;
    @(negedge clk);
    run_scan(8, -1, dc, nr);
    chk("n8_done_cycle", dc, 10);
    chk("n8_bestIdx", bestIdx, 7);
    chk("n8_bestID", bestID, 107);
    @(negedge clk);

    // Q/hops ordering
    t_q[0] = 10; t_q[1] = 40; t_q[2] = 25; t_q[3] = 40;
    t_hops[0] = 3; t_hops[1] = 5; t_hops[2] = 2; t_hops[3] = 4;
    run_scan(4, -1, dc, nr);
    chk("n4_done_cycle", dc, 6);
    chk("n4_valid", valid, 1);
    chk("n4_bestIdx", bestIdx, 3);
    chk("n4_bestQ", bestQValue, 40);
    chk("n4_bestHops", bestHops, 4);
    @(negedge clk);

    // Full tie
    for (int k = 0; k < 3; k++) begin t_q[k] = 7; t_hops[k] = 2; end
    run_scan(3, -1, dc, nr);
    chk("tie_bestIdx", bestIdx, 0);
    chk("tie_reads", nr, 3);
    chk("tie_addr0", addr_log[0], 0);
    chk("tie_addr1", addr_log[1], 1);
    chk("tie_addr2", addr_log[2], 2);
    @(negedge clk);

    // Energy filter
    minEnergy = 16'd100;
    t_en[0] = 50; t_en[1] = 120; t_en[2] = 99;
    t_q[0] = 90;  t_q[1] = 10;   t_q[2] = 80;
    run_scan(3, -1, dc, nr);
`ifdef NEXT_HOP_ENERGY_FILTER_EN
    chk("energy_bestIdx", bestIdx, 1);
    chk("energy_bestQ", bestQValue, 10);
`else
    chk("energy_bestIdx", bestIdx, 0);
    chk("energy_bestQ", bestQValue, 90);
`endif
    @(negedge clk);
    table_default();

    // Empty table, then oversize count clamped to the table size
    run_scan(0, -1, dc, nr);
    chk("n0_done_cycle", dc, 1);
    chk("n0_valid", valid, 0);
    chk("n0_reads", nr, 0);
    @(negedge clk);
    run_scan(40, -1, dc, nr);
    chk("n40_reads", nr, 16);
    chk("n40_done_cycle", dc, 18);
    chk("n40_bestIdx", bestIdx, 15);
    @(negedge clk);

    // Start pulse mid-scan is ignored; start right after done is accepted
    run_scan(5, 2, dc, nr);
    chk("pulse_done_cycle", dc, 7);
    chk("pulse_reads", nr, 5);
    @(negedge clk);
    run_scan(3, -1, dc, nr);
    chk("b2b_done_cycle", dc, 5);
    chk("b2b_bestIdx", bestIdx, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
